// File: rtl/conv_window_gen_pkg.sv
// Shared types and constants for the 3x3 sliding-window generator.
package conv_window_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } cwg_state_e;

  localparam int unsigned CWG_WIN_NUM      = 9;
  localparam int unsigned CWG_WIN_DIM      = 3;
  localparam int unsigned CWG_MAX_LINE_LEN = 320;

  // First lane of each window row; the rightmost lane of a row is base + 2.
  localparam int unsigned LANE_TOP = 0;
  localparam int unsigned LANE_MID = 3;
  localparam int unsigned LANE_BOT = 6;

endpackage

// File: rtl/conv_line_buf.sv
// One image row of pixel storage: synchronous write, combinational read at the same address.
module conv_line_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 320,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rd_data_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read sees the old contents during the write cycle, giving read-before-write.
  assign rd_data_c = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream to 3x3 window generator (valid-only convolution, no padding).
// Optional build macro CONV_WIN_STRIDE2_EN: emit windows at stride 2 in both directions.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned WIN_NUM          = CWG_WIN_NUM,
  parameter int unsigned MAX_LINE_LEN     = CWG_MAX_LINE_LEN,
  parameter int unsigned ROW_BUFFER_DEPTH = 9,
  parameter int unsigned ROW_CNT_WIDTH    = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_in,
  input  logic [ROW_BUFFER_DEPTH-1:0]     line_len_in,
  input  logic [ROW_CNT_WIDTH-1:0]        frame_rows_in,
  input  logic [DATA_WIDTH-1:0]           pix_in,
  input  logic                            pix_valid_in,
  output logic                            pix_ready_out,
  output logic [WIN_NUM*DATA_WIDTH-1:0]   win_data_out,
  output logic                            win_valid_out,
  output logic                            frame_done_out,
  output logic                            cfg_err_out
);

  localparam int unsigned ADDR_W = $clog2(MAX_LINE_LEN);

  cwg_state_e state_q, state_d;

  logic [ROW_BUFFER_DEPTH-1:0] col_q, line_last_q;
  logic [ROW_CNT_WIDTH-1:0]    row_q, row_last_q;
  logic [WIN_NUM-1:0][DATA_WIDTH-1:0] win_q;

  logic [DATA_WIDTH-1:0] buf_a_rd, buf_b_rd;
  logic xfer, cfg_ok, col_last, row_last, stride_ok;
  logic ready_d, win_valid_d, done_d, err_d;

  assign xfer     = pix_valid_in & pix_ready_out;
  assign col_last = (col_q == line_last_q);
  assign row_last = (row_q == row_last_q);
  assign cfg_ok   = (line_len_in >= ROW_BUFFER_DEPTH'(3)) &&
                    (line_len_in <= ROW_BUFFER_DEPTH'(MAX_LINE_LEN)) &&
                    (frame_rows_in >= ROW_CNT_WIDTH'(3));

`ifdef CONV_WIN_STRIDE2_EN
  // Rows and columns start at 2, so even (row-2)/(col-2) means even row/col.
  assign stride_ok = ~row_q[0] & ~col_q[0];
`else
  assign stride_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    win_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (cfg_ok) state_d = ST_FILL;
          else        err_d   = 1'b1;
        end
      end
      ST_FILL: begin
        if (xfer && col_last && (row_q == ROW_CNT_WIDTH'(1))) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer) begin
          win_valid_d = (col_q >= ROW_BUFFER_DEPTH'(2)) && stride_ok;
          if (col_last && row_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_FILL) || (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_ready_out  <= 1'b0;
      win_valid_out  <= 1'b0;
      frame_done_out <= 1'b0;
      cfg_err_out    <= 1'b0;
    end else begin
      pix_ready_out  <= ready_d;
      win_valid_out  <= win_valid_d;
      frame_done_out <= done_d;
      cfg_err_out    <= err_d;
    end
  end

  // Config latch, raster counters and window shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      line_last_q <= '0;
      row_last_q  <= '0;
      win_q       <= '0;
    end else if ((state_q == ST_IDLE) && start_in && cfg_ok) begin
      col_q       <= '0;
      row_q       <= '0;
      line_last_q <= ROW_BUFFER_DEPTH'(line_len_in - ROW_BUFFER_DEPTH'(1));
      row_last_q  <= ROW_CNT_WIDTH'(frame_rows_in - ROW_CNT_WIDTH'(1));
    end else if (xfer) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= ROW_CNT_WIDTH'(row_q + ROW_CNT_WIDTH'(1));
      end else begin
        col_q <= ROW_BUFFER_DEPTH'(col_q + ROW_BUFFER_DEPTH'(1));
      end
      for (int unsigned r = 0; r < CWG_WIN_DIM; r++) begin
        win_q[r*CWG_WIN_DIM]     <= win_q[r*CWG_WIN_DIM + 1];
        win_q[r*CWG_WIN_DIM + 1] <= win_q[r*CWG_WIN_DIM + 2];
      end
      win_q[LANE_TOP + 2] <= buf_b_rd;
      win_q[LANE_MID + 2] <= buf_a_rd;
      win_q[LANE_BOT + 2] <= pix_in;
    end
  end

  assign win_data_out = win_q;

  // Buffer A holds the previous row; its old value cascades into B (two rows back).
  conv_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_LINE_LEN),
    .ADDR_W     (ADDR_W)
  ) u_buf_a (
    .clk       (clk),
    .we        (xfer),
    .addr      (ADDR_W'(col_q)),
    .wdata     (pix_in),
    .rd_data_c (buf_a_rd)
  );

  conv_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_LINE_LEN),
    .ADDR_W     (ADDR_W)
  ) u_buf_b (
    .clk       (clk),
    .we        (xfer),
    .addr      (ADDR_W'(col_q)),
    .wdata     (buf_a_rd),
    .rd_data_c (buf_b_rd)
  );

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: driver pushes expected windows, monitor pops on win_valid_out.
module tb_conv_window_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned WW = 9 * DW;

`ifdef CONV_WIN_STRIDE2_EN
  localparam int N_5X5   = 4;
  localparam int N_320X3 = 159;
`else
  localparam int N_5X5   = 9;
  localparam int N_320X3 = 318;
`endif

  localparam logic [WW-1:0] FIRST_5X5 =
    {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
  localparam logic [WW-1:0] LAST_5X5 =
    {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic [8:0]    line_len_in;
  logic [8:0]    frame_rows_in;
  logic [DW-1:0] pix_in;
  logic          pix_valid_in;
  logic          pix_ready_out;
  logic [WW-1:0] win_data_out;
  logic          win_valid_out;
  logic          frame_done_out;
  logic          cfg_err_out;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  bit first_seen = 1'b0;
  logic [WW-1:0] first_win = '0;
  logic [WW-1:0] last_win = '0;

  conv_window_gen dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .line_len_in    (line_len_in),
    .frame_rows_in  (frame_rows_in),
    .pix_in         (pix_in),
    .pix_valid_in   (pix_valid_in),
    .pix_ready_out  (pix_ready_out),
    .win_data_out   (win_data_out),
    .win_valid_out  (win_valid_out),
    .frame_done_out (frame_done_out),
    .cfg_err_out    (cfg_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pix_at(input int r, input int c, input int len);
    return DW'(r * len + c);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int r, input int c, input int len);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = pix_at(r - 2 + i, c - 2 + j, len);
    return w;
  endfunction

  function automatic bit stride_hit(input int r, input int c);
`ifdef CONV_WIN_STRIDE2_EN
    return (((r - 2) % 2) == 0) && (((c - 2) % 2) == 0);
`else
    return (r >= 0) && (c >= 0);
`endif
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (win_valid_out) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_window: got %h, expected no window", win_data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("win_data", win_data_out, mon_e.data);
        check("win_done", WW'(frame_done_out), WW'(mon_e.done));
      end
      win_cnt++;
      if (!first_seen) first_win = win_data_out;
      first_seen = 1'b1;
      last_win = win_data_out;
    end
    if (frame_done_out) done_cnt++;
  end

  task automatic do_start(input int len, input int rows);
    @(posedge clk); #1;
    start_in      = 1'b1;
    line_len_in   = 9'(len);
    frame_rows_in = 9'(rows);
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  // Streams a frame; stop_after > 0 cuts it short after that many transfers.
  task automatic run_frame(input int len, input int rows, input bit gap, input int stop_after);
    int n;
    int k;
    win_cnt    = 0;
    first_seen = 1'b0;
    do_start(len, rows);
    n = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < len; c++) begin
        if (stop_after != 0 && n == stop_after) return;
        pix_in       = pix_at(r, c, len);
        pix_valid_in = 1'b1;
        @(negedge clk);
        k = 0;
        while (!pix_ready_out && k < 20) begin
          @(negedge clk);
          k++;
        end
        if (!pix_ready_out) begin
          n_vec++;
          n_err++;
          $display("FAIL ready_timeout: got ready=0 at r=%0d c=%0d, expected ready=1", r, c);
          pix_valid_in = 1'b0;
          return;
        end
        if (r >= 2 && c >= 2 && stride_hit(r, c))
          exp_q.push_back('{data: exp_win(r, c, len), done: (r == rows - 1) && (c == len - 1)});
        @(posedge clk); #1;
        pix_valid_in = 1'b0;
        n++;
        if (gap) begin
          pix_in = DW'($urandom);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic frame_checks(input string tag, input int n_exp, input int d0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_win_count"}, WW'(win_cnt), WW'(n_exp));
    check({tag, "_pending"}, WW'(exp_q.size()), WW'(0));
    check({tag, "_done_pulses"}, WW'(done_cnt - d0), WW'(1));
    check({tag, "_ready_idle"}, WW'(pix_ready_out), WW'(0));
  endtask

  task automatic cfg_err_case(input string tag, input int len, input int rows);
    do_start(len, rows);
    check({tag, "_err_pulse"}, WW'(cfg_err_out), WW'(1));
    check({tag, "_err_ready"}, WW'(pix_ready_out), WW'(0));
    @(posedge clk); #1;
    check({tag, "_err_clear"}, WW'(cfg_err_out), WW'(0));
    check({tag, "_err_ready2"}, WW'(pix_ready_out), WW'(0));
  endtask

  initial begin
    int d0;
    rst           = 1'b1;
    start_in      = 1'b0;
    line_len_in   = '0;
    frame_rows_in = '0;
    pix_in        = '0;
    pix_valid_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", WW'(pix_ready_out), WW'(0));
    check("rst_valid", WW'(win_valid_out), WW'(0));
    check("rst_data", win_data_out, WW'(0));
    check("rst_done", WW'(frame_done_out), WW'(0));
    check("rst_err", WW'(cfg_err_out), WW'(0));
    rst = 1'b0;

    // 5x5 ramp, continuous valid.
    d0 = done_cnt;
    run_frame(5, 5, 1'b0, 0);
    frame_checks("f55", N_5X5, d0);
    check("f55_first", first_win, FIRST_5X5);
    check("f55_last", last_win, LAST_5X5);

    // Same frame with valid toggling every cycle.
    d0 = done_cnt;
    run_frame(5, 5, 1'b1, 0);
    frame_checks("f55gap", N_5X5, d0);
    check("f55gap_first", first_win, FIRST_5X5);
    check("f55gap_last", last_win, LAST_5X5);

    // Maximum line length, minimum rows.
    d0 = done_cnt;
    run_frame(320, 3, 1'b0, 0);
    frame_checks("f320", N_320X3, d0);
    check("f320_first_top", WW'(first_win[23:0]), WW'(24'h020100));

    // Illegal configurations.
    cfg_err_case("len2", 2, 5);
    cfg_err_case("rows2", 5, 2);
    cfg_err_case("len321", 321, 3);

    // Reset mid-frame after 13 pixels, then a clean frame.
    run_frame(5, 5, 1'b0, 13);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", WW'(pix_ready_out), WW'(0));
    check("midrst_valid", WW'(win_valid_out), WW'(0));
    check("midrst_data", win_data_out, WW'(0));
    check("midrst_done", WW'(frame_done_out), WW'(0));
    check("midrst_pending", WW'(exp_q.size()), WW'(0));
    check("midrst_partial_wins", WW'(win_cnt), WW'(1));
    rst = 1'b0;
    d0 = done_cnt;
    run_frame(5, 5, 1'b0, 0);
    frame_checks("f55post", N_5X5, d0);
    check("f55post_first", first_win, FIRST_5X5);
    check("f55post_last", last_win, LAST_5X5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
